// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: IDLE/EXEC/RESP, one op in flight.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin contention; default build is fixed port-0 priority.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req0_valid_i,
  input  logic             req1_valid_i,
  output logic             req0_ready_o,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req0_op0_i,
  input  logic [WIDTH-1:0] req0_op1_i,
  input  logic [WIDTH-1:0] req1_op0_i,
  input  logic [WIDTH-1:0] req1_op1_i,
  input  logic [3:0]       req0_control_i,
  input  logic [3:0]       req1_control_i,
  output logic [WIDTH-1:0] alu_operand0_o,
  output logic [WIDTH-1:0] alu_operand1_o,
  output logic [3:0]       alu_control_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_zero_i,
  input  logic             alu_overflow_i,
  output logic             rsp0_valid_o,
  output logic             rsp1_valid_o,
  input  logic             rsp0_ready_i,
  input  logic             rsp1_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_zero_o,
  output logic             rsp_overflow_o,
  output logic             rsp_illegal_o
);

  // state | meaning
  // IDLE  | no op in flight; grant one requester
  // EXEC  | captured operands drive the ALU; result sampled at end of cycle
  // RESP  | response held for the owning port until it is consumed
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             port_q, port_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d;
  logic             gnt1, hs, idle_ok, illegal_op;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic prio_q, prio_d;

  assign gnt1   = req1_valid_i && (!req0_valid_i || prio_q);
  // After any accept the pointer favours the port that did not just win.
  assign prio_d = hs ? ~gnt1 : prio_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) prio_q <= 1'b0;
    else         prio_q <= prio_d;
  end
`else
  assign gnt1 = req1_valid_i && !req0_valid_i;
`endif

  // Operand registers double as the ALU drive, so they hold outside EXEC.
  assign idle_ok        = (state_q == IDLE) && !reset_i;
  assign req0_ready_o   = idle_ok && req0_valid_i && !gnt1;
  assign req1_ready_o   = idle_ok && gnt1;
  assign hs             = req0_ready_o || req1_ready_o;
  assign illegal_op     = (ctrl_q[3:2] == 2'b11);

  assign alu_operand0_o = opa_q;
  assign alu_operand1_o = opb_q;
  assign alu_control_o  = ctrl_q;
  assign rsp0_valid_o   = (state_q == RESP) && !port_q;
  assign rsp1_valid_o   = (state_q == RESP) && port_q;
  assign rsp_result_o   = res_q;
  assign rsp_zero_o     = zero_q;
  assign rsp_overflow_o = ovf_q;
  assign rsp_illegal_o  = ill_q;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    ctrl_d  = ctrl_q;
    port_d  = port_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          opa_d   = gnt1 ? req1_op0_i     : req0_op0_i;
          opb_d   = gnt1 ? req1_op1_i     : req0_op1_i;
          ctrl_d  = gnt1 ? req1_control_i : req0_control_i;
          port_d  = gnt1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = illegal_op ? '0 : alu_result_i;
        zero_d  = illegal_op || alu_zero_i;
        ovf_d   = !illegal_op && alu_overflow_i;
        ill_d   = illegal_op;
        state_d = RESP;
      end
      RESP: begin
        if (port_q ? rsp1_ready_i : rsp0_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      ctrl_q  <= '0;
      port_q  <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      ctrl_q  <= ctrl_d;
      port_q  <= port_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected responses queued at accept, compared on consume.
module tb_alu_arbiter;
  localparam int W = 32;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_i;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_op0, req0_op1, req1_op0, req1_op1;
  logic [3:0]   req0_control, req1_control;
  logic [W-1:0] alu_operand0, alu_operand1, alu_result;
  logic [3:0]   alu_control;
  logic         alu_zero, alu_ovf;
  logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_zero, rsp_ovf, rsp_ill;

  typedef struct packed {
    logic         port;
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
    logic         ill;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req0_valid_i(req0_valid), .req1_valid_i(req1_valid),
    .req0_ready_o(req0_ready), .req1_ready_o(req1_ready),
    .req0_op0_i(req0_op0), .req0_op1_i(req0_op1),
    .req1_op0_i(req1_op0), .req1_op1_i(req1_op1),
    .req0_control_i(req0_control), .req1_control_i(req1_control),
    .alu_operand0_o(alu_operand0), .alu_operand1_o(alu_operand1),
    .alu_control_o(alu_control),
    .alu_result_i(alu_result), .alu_zero_i(alu_zero), .alu_overflow_i(alu_ovf),
    .rsp0_valid_o(rsp0_valid), .rsp1_valid_o(rsp1_valid),
    .rsp0_ready_i(rsp0_ready), .rsp1_ready_i(rsp1_ready),
    .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero),
    .rsp_overflow_o(rsp_ovf), .rsp_illegal_o(rsp_ill)
  );

  // External ALU stand-in: {result, zero, overflow}
  function automatic logic [W+1:0] alu_model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         v;
    v = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0100: begin r = a + b; v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      4'b0110: begin r = a - b; v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      default: r = a ^ b;
    endcase
    return {r, (r == '0), v};
  endfunction

  always_comb {alu_result, alu_zero, alu_ovf} = alu_model(alu_control, alu_operand0, alu_operand1);

  // Scoreboard compare at every consumed response
  always @(negedge clk) begin
    if (!reset_i && ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: port %0d result %h arrived, none expected", rsp1_valid, rsp_result);
      end else begin
        mon_e = sb_q.pop_front();
        if ({rsp1_valid, rsp_result, rsp_zero, rsp_ovf, rsp_ill} !== mon_e) begin
          failures++;
          $display("FAIL sb_response: got port=%0d res=%h z=%b o=%b i=%b, want port=%0d res=%h z=%b o=%b i=%b",
                   rsp1_valid, rsp_result, rsp_zero, rsp_ovf, rsp_ill,
                   mon_e.port, mon_e.res, mon_e.zero, mon_e.ovf, mon_e.ill);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset_i = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_i = 1'b0;
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 back in IDLE.
  task automatic run_op(input logic port, input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eres, input logic ez, input logic eo, input logic ei);
    exp_t e;
    req0_valid = !port;
    req1_valid = port;
    if (port) begin req1_op0 = a; req1_op1 = b; req1_control = ctrl; end
    else      begin req0_op0 = a; req0_op1 = b; req0_control = ctrl; end
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({req1_ready, req0_ready} !== (port ? 2'b10 : 2'b01)) begin
      failures++;
      $display("FAIL accept: readys(1,0)=%b, want port %0d", {req1_ready, req0_ready}, port);
    end
    e = {port, eres, ez, eo, ei};
    sb_q.push_back(e);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp1_valid, rsp0_valid} !== 2'b00 || alu_operand0 !== a || alu_operand1 !== b || alu_control !== ctrl) begin
      failures++;
      $display("FAIL exec: rspv=%b op0=%h op1=%h ctl=%h, want rspv=00 op0=%h op1=%h ctl=%h",
               {rsp1_valid, rsp0_valid}, alu_operand0, alu_operand1, alu_control, a, b, ctrl);
    end
    @(negedge clk);
    checks++;
    if ((port ? rsp1_valid : rsp0_valid) !== 1'b1) begin
      failures++;
      $display("FAIL latency: rsp%0d_valid=%b at T+2, want 1", port, port ? rsp1_valid : rsp0_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready: readys=%b during reset, want 00", {req1_ready, req0_ready});
    end
    checks++;
    if ({rsp1_valid, rsp0_valid, rsp_zero, rsp_ovf, rsp_ill} !== 5'b0 || rsp_result !== '0 ||
        alu_operand0 !== '0 || alu_operand1 !== '0 || alu_control !== 4'h0) begin
      failures++;
      $display("FAIL reset_values: rspv=%b res=%h z=%b o=%b i=%b op0=%h op1=%h ctl=%h, want all 0",
               {rsp1_valid, rsp0_valid}, rsp_result, rsp_zero, rsp_ovf, rsp_ill, alu_operand0, alu_operand1, alu_control);
    end
    @(posedge clk);
    #1 reset_i = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_add();
    run_op(1'b0, 4'b0100, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sub_zero();
    run_op(1'b0, 4'b0110, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_illegal();
    run_op(1'b1, 4'b1110, 32'd3, 32'd4, 32'd0, 1'b1, 1'b0, 1'b1);
    run_op(1'b0, 4'b1100, 32'hFFFF_FFFF, 32'h1, 32'd0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_arbitration();
    exp_t e;
    logic g;
    do_reset();
    req0_op0 = 32'd20;         req0_op1 = 32'd22; req0_control = 4'b0100;
    req1_op0 = 32'h7FFF_FFFF;  req1_op1 = 32'd1;  req1_control = 4'b0100;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      g = RR ? i[0] : 1'b0;
      @(negedge clk);
      checks++;
      if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL arb_grant%0d: readys(1,0)=%b, want grant to port %0d", i, {req1_ready, req0_ready}, g);
      end
      e = g ? {1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0} : {1'b0, 32'd42, 1'b0, 1'b0, 1'b0};
      sb_q.push_back(e);
      @(negedge clk);
      checks++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        failures++;
        $display("FAIL arb_busy%0d: readys=%b in EXEC, want 00", i, {req1_ready, req0_ready});
      end
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_back_to_back_stall();
    exp_t e;
    req0_valid = 1'b1; req0_op0 = 32'hF0; req0_op1 = 32'h0F; req0_control = 4'b0001;
    req1_valid = 1'b0; req1_op0 = 32'hFF; req1_op1 = 32'h3C; req1_control = 4'b0000;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_accept: req0_ready=%b, want 1", req0_ready);
    end
    e = {1'b0, 32'hFF, 1'b0, 1'b0, 1'b0};
    sb_q.push_back(e);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    req1_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_result !== 32'hFF || rsp_ill !== 1'b0 || req1_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d: rsp0v=%b rsp1v=%b res=%h ill=%b req1_ready=%b, want 1 0 ff 0 0",
                 i, rsp0_valid, rsp1_valid, rsp_result, rsp_ill, req1_ready);
      end
    end
    @(posedge clk);
    #1 rsp0_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: req1_ready=%b while still in RESP, want 0", req1_ready);
    end
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_next: req1_ready=%b one cycle after rsp0_ready, want 1", req1_ready);
    end
    e = {1'b1, 32'h3C, 1'b0, 1'b0, 1'b0};
    sb_q.push_back(e);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp1_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_rsp1: rsp1_valid=%b, want 1", rsp1_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_in_exec();
    logic seen;
    req0_valid = 1'b1; req0_op0 = 32'd1; req0_op1 = 32'd1; req0_control = 4'b0100;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL rexec_accept: req0_ready=%b, want 1", req0_ready);
    end
    @(posedge clk);
    #1 req0_valid = 1'b0;
    reset_i = 1'b1;
    @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp1_valid, rsp0_valid} !== 2'b00 || alu_operand0 !== '0) begin
      failures++;
      $display("FAIL rexec_drop: rspv=%b op0=%h after reset, want 00 and 0", {rsp1_valid, rsp0_valid}, alu_operand0);
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen = seen | rsp0_valid | rsp1_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL rexec_silent: response seen for dropped op, want none");
    end
    @(posedge clk);
    #1;
    run_op(1'b0, 4'b0100, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_i = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op0 = '0; req0_op1 = '0; req1_op0 = '0; req1_op1 = '0;
    req0_control = '0; req1_control = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    test_reset();
    test_add();
    test_sub_zero();
    test_illegal();
    test_arbitration();
    test_back_to_back_stall();
    test_reset_in_exec();

    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d responses still expected, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width; SHALL match the ALU datapath width.
REQ-002 clk  input  1  system clock; all state SHALL update on rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester N has an operation pending.
REQ-005 req0_ready / req1_ready  output  1 each  arbiter accepts requester N this cycle.
REQ-006 req0_op0, req0_op1, req1_op0, req1_op1  input  WIDTH each  operands per requester.
REQ-007 req0_control / req1_control  input  4 each  ALU function code per requester.
REQ-008 alu_operand0, alu_operand1  output  WIDTH each  operands driven to the shared ALU.
REQ-009 alu_control  output  4  function code driven to the shared ALU.
REQ-010 alu_result  input  WIDTH  ALU result.
REQ-011 alu_zero, alu_overflow  input  1 each  ALU flags.
REQ-012 rsp0_valid / rsp1_valid  output  1 each  response is for requester N.
REQ-013 rsp0_ready / rsp1_ready  input  1 each  requester N consumes the response.
REQ-014 rsp_result  output  WIDTH  shared response bus.
REQ-015 rsp_zero, rsp_overflow, rsp_illegal  output  1 each  shared response flags.

Function
REQ-016 States SHALL be IDLE, EXEC and RESP; at most one operation SHALL be outstanding.
REQ-017 In IDLE, reqN_ready SHALL be 1 only for the granted port, combinationally from the valids and the priority pointer; it SHALL be 0 for both ports in EXEC and RESP.
REQ-018 Grant: only one valid port, that port wins; both valid, the port selected by the priority logic in REQ-031/REQ-032 wins.
REQ-019 On a handshake (valid && ready), the operands, control and port ID SHALL be registered and the state SHALL go IDLE->EXEC.
REQ-020 In EXEC, alu_operand0/1 and alu_control SHALL be driven from the registers; alu_result, alu_zero and alu_overflow SHALL be captured into the rsp_* registers; the state SHALL go EXEC->RESP.
REQ-021 In RESP, rspN_valid for the captured port SHALL be held at 1, with the rsp_* values stable, until rspN_ready=1; then the state SHALL go RESP->IDLE.
REQ-022 Latency: acceptance at cycle T SHALL give rspN_valid=1 from cycle T+2; the minimum initiation interval SHALL be 3 cycles.
REQ-023 Control codes 4'b1100-4'b1111 SHALL be accepted, but rsp_result SHALL be 0, rsp_zero=1, rsp_overflow=0 and rsp_illegal=1; for codes 0-11, rsp_illegal SHALL be 0.
REQ-024 Outside EXEC, the alu_* outputs SHALL hold their last driven values.
REQ-025 rspN_ready asserted while rspN_valid=0, or asserted for the other port, SHALL be ignored.
REQ-026 A requester deasserting valid before its handshake SHALL lose no state; the grant SHALL be re-evaluated every IDLE cycle.

Reset
REQ-027 While reset=1 on a rising edge, the state SHALL become IDLE and any in-flight operation SHALL be dropped without a response.
REQ-028 Reset values SHALL be: rsp0_valid=rsp1_valid=0, rsp_result=0, rsp_zero=0, rsp_overflow=0, rsp_illegal=0, alu_operand0=alu_operand1=0, alu_control=0, priority pointer=port 0.
REQ-029 Because reqN_ready is combinational from state and pointer, both readys SHALL read 0 while reset is asserted.
REQ-030 On the first cycle after reset deasserts, the block SHALL accept a request.

Configuration
REQ-031 With the macro ALU_ARB_ROUND_ROBIN_EN defined, a simultaneous request SHALL be granted to the port the pointer names, and the pointer SHALL move to the other port after each handshake.
REQ-032 With ALU_ARB_ROUND_ROBIN_EN undefined, port 0 SHALL always win a simultaneous request, the pointer SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-033 reset, then req0 ADD (control 4'b0100) with 5 and 7, rsp0_ready=1 -> req0_ready=1 at T; rsp0_valid=1 at T+2 with rsp_result=12, zero=0, overflow=0, illegal=0.
REQ-034 req0 SUB (4'b0110) with 9 and 9 -> rsp_result=0, rsp_zero=1.
REQ-035 Both ports valid continuously for 4 operations -> with ALU_ARB_ROUND_ROBIN_EN, grants go 0,1,0,1; without it, grants go 0,0,0,0.
REQ-036 req1 control 4'b1110 with 3 and 4 -> rsp1_valid=1, rsp_result=0, rsp_zero=1, rsp_illegal=1.
REQ-037 Hold rsp0_ready=0 for 5 cycles with req1_valid=1 -> rsp0_valid and rsp_* stay stable and req1_ready stays 0; one cycle after rsp0_ready=1, req1_ready=1.
REQ-038 Assert reset in EXEC -> the next cycle has rsp0_valid=rsp1_valid=0 and the state is IDLE, with no response for the dropped operation.
